// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader with XOR checksum.
// Holds the core in reset until a frame loads cleanly.
module imem_loader #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int          IW   = $clog2(MEM_WORDS + 1);
  localparam logic [16:0] MAXN = 17'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state_q;
  logic [7:0]    hi_q;
  logic [15:0]   n_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    bcnt_q;
  logic [23:0]   asm_q;
  logic [7:0]    xor_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          cpu_reset_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic [15:0]   n_d;
  logic [15:0]   idx_inc_d;
  logic [31:0]   waddr_d;
  logic [7:0]    xor_d;

  // Handshake decode and per-byte helper values.
  always_comb begin
    in_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                (state_q == S_DATA)   || (state_q == S_CSUM);
    accept    = in_valid && in_ready;
    n_d       = {hi_q, in_data};
    idx_inc_d = 16'(idx_q) + 16'd1;
    waddr_d   = BASE_ADDR + (32'(idx_q) << 2);
    xor_d     = xor_q ^ in_data;
  end

  // Frame parser FSM with registered memory and core-control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CNT_HI;
      hi_q        <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_CNT_HI: begin
          if (accept) begin
            hi_q    <= in_data;
            xor_q   <= xor_d;
            state_q <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            n_q   <= n_d;
            xor_q <= xor_d;
            if ({1'b0, n_d} > MAXN) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else if (n_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_q <= xor_d;
            asm_q <= {asm_q[15:0], in_data};
            if (bcnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= waddr_d;
              mem_wdata_q <= {asm_q, in_data};
              idx_q       <= idx_q + 1'b1;
              bcnt_q      <= 2'd0;
              if (idx_inc_d == n_q) begin
                state_q <= S_CSUM;
              end
            end else begin
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == xor_q) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN, S_ERROR: begin
          if (reload) begin
            state_q     <= S_CNT_HI;
            idx_q       <= '0;
            bcnt_q      <= '0;
            xor_q       <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= S_CNT_HI;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-position
// frame model and directed test-plan checks.
module tb_imem_loader;

  localparam int          MW = 256;
  localparam logic [31:0] BA = 32'h0000_0000;
  localparam int LD = 0;
  localparam int RN = 1;
  localparam int ER = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  imem_loader #(
    .MEM_WORDS(MW),
    .BASE_ADDR(BA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .reload(reload),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  int          m_mode;
  int          m_pos;
  int          m_n;
  logic [7:0]  m_x;
  logic [31:0] m_word;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  logic [63:0] wlog[$];
  int          wtime[$];
  logic [7:0]  frm[$];

  task automatic check1(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc_n);
    end
  endtask

  // One clock: compare, drive, then advance the model.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic rl, output logic acc);
    @(negedge clk);
    check1("in_ready", 32'(in_ready), 32'(m_mode == LD));
    check1("mem_we", 32'(mem_we), 32'(exp_we));
    check1("mem_addr", mem_addr, exp_addr);
    check1("mem_wdata", mem_wdata, exp_wdata);
    check1("cpu_reset", 32'(cpu_reset), 32'(m_mode != RN));
    check1("done", 32'(done), 32'(m_mode == RN));
    check1("err", 32'(err), 32'(m_mode == ER));
    if (mem_we === 1'b1) begin
      wlog.push_back({mem_addr, mem_wdata});
      wtime.push_back(cyc_n);
    end
    reset = r;
    in_valid = v;
    in_data = d;
    reload = rl;
    acc = !r && v && (m_mode == LD);
    exp_we = 1'b0;
    if (r) begin
      m_mode = LD;
      m_pos = 0;
      m_x = 8'h00;
      m_word = 32'h0;
      exp_addr = BA;
      exp_wdata = 32'h0;
    end else if (m_mode == LD) begin
      if (v) begin
        if (m_pos == 0) begin
          m_n = int'(d) << 8;
          m_x ^= d;
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_n = m_n | int'(d);
          m_x ^= d;
          m_pos = 2;
          if (m_n > MW) m_mode = ER;
        end else if (m_pos < 2 + 4 * m_n) begin
          m_word = {m_word[23:0], d};
          m_x ^= d;
          if ((m_pos - 2) % 4 == 3) begin
            exp_we = 1'b1;
            exp_addr = BA + 32'(4 * ((m_pos - 2) / 4));
            exp_wdata = m_word;
          end
          m_pos++;
        end else begin
          m_mode = (d == m_x) ? RN : ER;
        end
      end
    end else if (rl) begin
      m_mode = LD;
      m_pos = 0;
      m_x = 8'h00;
    end
    cyc_n++;
  endtask

  task automatic idle(input int k);
    logic a;
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic do_reload();
    logic a;
    if (m_mode != LD) cyc(1'b0, 1'b0, 8'h00, 1'b1, a);
  endtask

  // sm: 0 = every cycle, 1 = toggle, 2 = random gaps.
  task automatic send(input int sm, input int cut);
    logic a;
    logic v;
    int ph;
    int guard;
    ph = 0;
    for (int i = 0; i < frm.size(); i++) begin
      if (cut == i) begin
        cyc(1'b1, 1'b1, frm[i], 1'b0, a);
        return;
      end
      if (m_mode != LD) begin
        cyc(1'b0, 1'b1, frm[i], 1'b0, a);
        continue;
      end
      guard = 0;
      do begin
        if (sm == 0) v = 1'b1;
        else if (sm == 1) v = (ph % 2 == 0);
        else v = ($urandom_range(0, 2) != 0);
        ph++;
        guard++;
        cyc(1'b0, v, frm[i], ($urandom_range(0, 7) == 0), a);
      end while (!a && guard < 100);
      if (!a) begin
        miscompares++;
        $display("FAIL send_timeout: byte %0d not accepted", i);
        return;
      end
    end
  endtask

  task automatic build(input int n, input logic bad);
    logic [7:0]  x;
    logic [31:0] w;
    int nw;
    frm.delete();
    frm.push_back(8'(n >> 8));
    frm.push_back(8'(n));
    nw = (n <= MW) ? n : 1;
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      for (int b = 3; b >= 0; b--) frm.push_back(w[b*8 +: 8]);
    end
    x = 8'h00;
    foreach (frm[k]) x ^= frm[k];
    frm.push_back(x ^ {7'h0, bad});
  endtask

  task automatic nominal(input logic bad);
    logic [7:0] nb[11];
    nb = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h01, 8'h08, 8'h40, 8'h20, 8'h46};
    frm.delete();
    foreach (nb[k]) frm.push_back(nb[k]);
    if (bad) frm[10] = 8'h47;
  endtask

  task automatic check_nom_writes(input string tag);
    check1({tag, "_wcount"}, 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check1({tag, "_a0"}, wlog[0][63:32], 32'h0);
      check1({tag, "_d0"}, wlog[0][31:0], 32'h2008_0005);
      check1({tag, "_a1"}, wlog[1][63:32], 32'h4);
      check1({tag, "_d1"}, wlog[1][31:0], 32'h0108_4020);
    end
  endtask

  initial begin
    logic a;
    int n;
    int cut;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    reload = 1'b0;
    m_mode = LD;
    m_pos = 0;
    m_n = 0;
    m_x = 8'h00;
    m_word = 32'h0;
    exp_we = 1'b0;
    exp_addr = BA;
    exp_wdata = 32'h0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, a);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, a);
    check1("rst_ready", 32'(in_ready), 32'd1);
    check1("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check1("rst_addr", mem_addr, 32'h0);

    wlog.delete();
    nominal(1'b0);
    send(0, -1);
    idle(2);
    check_nom_writes("nom");
    check1("nom_done", 32'(done), 32'd1);
    check1("nom_cpu_reset", 32'(cpu_reset), 32'd0);

    do_reload();
    wlog.delete();
    nominal(1'b1);
    send(0, -1);
    idle(2);
    check_nom_writes("bad");
    check1("bad_err", 32'(err), 32'd1);
    check1("bad_ready", 32'(in_ready), 32'd0);
    do_reload();
    idle(1);
    check1("reload_ready", 32'(in_ready), 32'd1);
    check1("reload_err", 32'(err), 32'd0);

    wlog.delete();
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(8'h01);
    repeat (6) frm.push_back(8'hA5);
    send(0, -1);
    idle(2);
    check1("ovr_wcount", 32'(wlog.size()), 32'd0);
    check1("ovr_err", 32'(err), 32'd1);

    do_reload();
    wlog.delete();
    frm.delete();
    repeat (3) frm.push_back(8'h00);
    send(0, -1);
    idle(2);
    check1("zero_wcount", 32'(wlog.size()), 32'd0);
    check1("zero_done", 32'(done), 32'd1);

    do_reload();
    wlog.delete();
    wtime.delete();
    nominal(1'b0);
    send(1, -1);
    idle(2);
    check_nom_writes("stall");
    check1("stall_done", 32'(done), 32'd1);
    if (wtime.size() == 2)
      check1("stall_gap", 32'(wtime[1] - wtime[0]), 32'd8);

    do_reload();
    wlog.delete();
    nominal(1'b0);
    send(0, 5);
    idle(3);
    check1("rmid_wcount", 32'(wlog.size()), 32'd0);
    nominal(1'b0);
    send(0, -1);
    idle(2);
    check_nom_writes("rmid");
    check1("rmid_done", 32'(done), 32'd1);
    check1("mdl_mode", 32'(m_mode), 32'(RN));

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 19))
        0: n = MW;
        1: n = MW + 1;
        2: n = 16'hFFFF;
        default: n = $urandom_range(0, 5);
      endcase
      build(n, ($urandom_range(0, 3) == 0));
      cut = ($urandom_range(0, 9) == 0) ?
            $urandom_range(0, frm.size() - 1) : -1;
      do_reload();
      send($urandom_range(0, 2), cut);
      idle($urandom_range(1, 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
